// File: rtl/spi_slave_ctrl.sv
// ADI-style 4-wire SPI responder: oversamples CSB/SCLK/SDI on I_clk, decodes the
// 16-bit instruction and drives the register file memory bus for read/write bursts.
module spi_slave_ctrl #(
  parameter int ADDR_SIZE   = 8,
  parameter int DATA_SIZE   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 I_clk,
  input  logic                 I_reset,
  input  logic                 I_csb,
  input  logic                 I_sclk,
  input  logic                 I_sdi,
  output logic                 O_sdo,
  output logic                 O_sdo_oe,
  output logic                 O_enable,
  output logic                 O_wen,
  output logic [ADDR_SIZE-1:0] O_addr,
  output logic [DATA_SIZE-1:0] O_din,
  input  logic [DATA_SIZE-1:0] I_dout
);

  typedef enum logic [1:0] {IDLE, INSTR, DATA, DONE} state_t;

  localparam logic [3:0] LAST_BIT = 4'(DATA_SIZE - 1);

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] csb_sync, sclk_sync, sdi_sync;
  logic                   csb_d, sclk_d;
  logic                   csb_s, sclk_s, sdi_s;
  logic                   csb_rise, csb_fall, sclk_rise, sclk_fall;

  logic [14:0]            sh;
  logic [DATA_SIZE-1:0]   tx_sh;
  logic [3:0]             bit_cnt;
  logic [1:0]             byte_cnt;
  logic                   rw, stream, load_pend;
  logic                   instr_done, byte_done, last_byte;
  logic [DATA_SIZE-1:0]   data_word;

  // Synchronizers clear to 0 so a reset taken mid-frame never sees a CSB fall
  // until CSB has first gone high again.
  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      csb_sync  <= '0;
      sclk_sync <= '0;
      sdi_sync  <= '0;
      csb_d     <= 1'b0;
      sclk_d    <= 1'b0;
    end else begin
      csb_sync  <= (csb_sync << 1)  | SYNC_STAGES'(I_csb);
      sclk_sync <= (sclk_sync << 1) | SYNC_STAGES'(I_sclk);
      sdi_sync  <= (sdi_sync << 1)  | SYNC_STAGES'(I_sdi);
      csb_d     <= csb_s;
      sclk_d    <= sclk_s;
    end
  end

  assign csb_s     = csb_sync[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign sdi_s     = sdi_sync[SYNC_STAGES-1];
  assign csb_rise  = csb_s & ~csb_d;
  assign csb_fall  = ~csb_s & csb_d;
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;

  assign instr_done = sclk_rise && (bit_cnt == 4'd15);
  assign byte_done  = sclk_rise && (bit_cnt == LAST_BIT);
  assign last_byte  = !stream && (byte_cnt == 2'd0);
  assign data_word  = {sh[DATA_SIZE-2:0], sdi_s};

  always_ff @(posedge I_clk) begin
    if (I_reset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Writes leave DATA on the strobe cycle so the final O_wen is still issued.
  always_comb begin
    state_d = state_q;
    if (csb_rise) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (csb_fall) state_d = INSTR;
        INSTR:   if (instr_done) state_d = DATA;
        DATA:    if (last_byte && (rw ? byte_done : O_wen)) state_d = DONE;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      O_sdo     <= 1'b0;
      O_sdo_oe  <= 1'b0;
      O_enable  <= 1'b0;
      O_wen     <= 1'b0;
      O_addr    <= '0;
      O_din     <= '0;
      sh        <= '0;
      tx_sh     <= '0;
      bit_cnt   <= '0;
      byte_cnt  <= '0;
      rw        <= 1'b0;
      stream    <= 1'b0;
      load_pend <= 1'b0;
    end else begin
      O_wen     <= 1'b0;
      load_pend <= 1'b0;
      if (csb_rise) begin
        // CSB rise beats a coincident SCLK edge; a partial byte is dropped.
        O_enable <= 1'b0;
        O_sdo_oe <= 1'b0;
        O_sdo    <= 1'b0;
        bit_cnt  <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (csb_fall) begin
              O_enable <= 1'b1;
              bit_cnt  <= '0;
            end
          end
          INSTR: begin
            if (sclk_rise) begin
              sh      <= {sh[13:0], sdi_s};
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd15) begin
                rw        <= sh[14];
                byte_cnt  <= sh[13:12];
                stream    <= &sh[13:12];
                O_addr    <= {sh[ADDR_SIZE-2:0], sdi_s};
                load_pend <= sh[14];
                bit_cnt   <= '0;
              end
            end
          end
          DATA: begin
            if (sclk_rise) bit_cnt <= (bit_cnt == LAST_BIT) ? 4'd0 : bit_cnt + 4'd1;
            if (rw) begin
              // I_dout follows O_addr combinationally; sample it one cycle after O_addr moves.
              if (load_pend) begin
                tx_sh <= I_dout;
              end else if (sclk_fall) begin
                O_sdo    <= tx_sh[DATA_SIZE-1];
                O_sdo_oe <= 1'b1;
                tx_sh    <= tx_sh << 1;
              end
              if (byte_done) begin
                O_addr <= O_addr - ADDR_SIZE'(1);
                if (last_byte) begin
                  O_sdo_oe <= 1'b0;
                  O_sdo    <= 1'b0;
                end else begin
                  load_pend <= 1'b1;
                  byte_cnt  <= byte_cnt - 2'd1;
                end
              end
            end else begin
              if (sclk_rise) sh <= {sh[13:0], sdi_s};
              if (byte_done) begin
                O_din <= data_word;
                O_wen <= 1'b1;
              end
              if (O_wen) begin
                O_addr <= O_addr - ADDR_SIZE'(1);
                if (!last_byte) byte_cnt <= byte_cnt - 2'd1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Bench for spi_slave_ctrl: table of SPI frames plus hand sequences for reset,
// abort and CSB/SCLK collision; register writes checked through a scoreboard queue.
module tb_spi_slave_ctrl;
  localparam int HALF = 80;

  logic       clk = 1'b0;
  logic       rst, csb, sclk, sdi;
  logic       sdo, sdo_oe, en, wen;
  logic [7:0] addr, din, dout;

  always #5 clk = ~clk;

  // Register file read model
  assign dout = (addr == 8'h01) ? 8'h01 : (addr ^ 8'h3C);

  spi_slave_ctrl #(.ADDR_SIZE(8), .DATA_SIZE(8), .SYNC_STAGES(2)) dut (
    .I_clk(clk), .I_reset(rst), .I_csb(csb), .I_sclk(sclk), .I_sdi(sdi),
    .O_sdo(sdo), .O_sdo_oe(sdo_oe), .O_enable(en), .O_wen(wen),
    .O_addr(addr), .O_din(din), .I_dout(dout)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed { logic [7:0] a; logic [7:0] d; } wr_t;
  wr_t sb[$];

  typedef struct {
    logic [15:0] instr;
    int          nbytes;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_oe_end;
  } vec_t;
  vec_t tbl[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0 && wen === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_wen: got addr 0x%0h din 0x%0h expected no write", addr, din);
      end else begin
        wr_t e;
        e = sb.pop_front();
        check("wen_addr", {24'h0, addr}, {24'h0, e.a});
        check("wen_din", {24'h0, din}, {24'h0, e.d});
        check("wen_enable", {31'h0, en}, 32'h1);
      end
    end
  end

  task automatic shift_bit(input logic b, output logic so, output logic oe);
    sdi = b;
    #HALF;
    so = sdo;
    oe = sdo_oe;
    sclk = 1'b1;
    #HALF;
    sclk = 1'b0;
  endtask

  task automatic frame_start();
    @(negedge clk);
    csb = 1'b0;
    #HALF;
  endtask

  task automatic send(input logic [15:0] instr, input int dbits, input logic [31:0] wdata,
                      output logic [31:0] rd, output int oe_cnt);
    logic so, oe;
    rd = '0;
    oe_cnt = 0;
    for (int i = 15; i >= 0; i--) shift_bit(instr[i], so, oe);
    for (int i = 0; i < dbits; i++) begin
      shift_bit(wdata[31-i], so, oe);
      rd[31-i] = so;
      oe_cnt += int'(oe);
    end
    #HALF;
  endtask

  task automatic frame_end();
    sdi = 1'b0;
    csb = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    logic [31:0] rd, mask;
    logic [7:0]  a;
    int          oc;
    logic        is_rd;

    tbl[0] = '{16'h0003, 1, 32'h5A00_0000, 32'h0000_0000, 1'b0};
    tbl[1] = '{16'h8001, 1, 32'h0000_0000, 32'h0100_0000, 1'b0};
    tbl[2] = '{16'h2003, 2, 32'h1122_0000, 32'h0000_0000, 1'b0};
    tbl[3] = '{16'hE000, 3, 32'h0000_0000, 32'h3CC3_C200, 1'b1};
    tbl[4] = '{16'h4001, 3, 32'hABCD_EF00, 32'h0000_0000, 1'b0};
    tbl[5] = '{16'hB081, 2, 32'h0000_0000, 32'hBDBC_0000, 1'b0};

    rst = 1'b1; csb = 1'b1; sclk = 1'b0; sdi = 1'b0;
    repeat (4) @(negedge clk);
    check("reset_state", {12'h0, en, wen, sdo, sdo_oe, addr, din}, 32'h0);
    rst = 1'b0;
    repeat (6) @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      is_rd = tbl[v].instr[15];
      if (!is_rd) begin
        for (int k = 0; k < tbl[v].nbytes; k++) begin
          a = tbl[v].instr[7:0] - 8'(k);
          sb.push_back({a, tbl[v].wdata[31-8*k -: 8]});
        end
      end
      frame_start();
      send(tbl[v].instr, 8 * tbl[v].nbytes, tbl[v].wdata, rd, oc);
      check($sformatf("v%0d_enable_mid", v), {31'h0, en}, 32'h1);
      check($sformatf("v%0d_oe_end", v), {31'h0, sdo_oe}, {31'h0, tbl[v].exp_oe_end});
      check($sformatf("v%0d_oe_bits", v), oc, is_rd ? 8 * tbl[v].nbytes : 0);
      if (is_rd) begin
        mask = 32'hFFFF_FFFF << (32 - 8 * tbl[v].nbytes);
        check($sformatf("v%0d_rdata", v), rd & mask, tbl[v].exp_rd);
      end
      frame_end();
      check($sformatf("v%0d_idle_pins", v), {29'h0, en, sdo_oe, sdo}, 32'h0);
      check($sformatf("v%0d_sb_drained", v), sb.size(), 0);
    end

    // Reset mid-frame: the rest of the frame must be ignored until CSB goes high.
    frame_start();
    send(16'h0010, 4, 32'hF000_0000, rd, oc);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_mid_outputs", {12'h0, en, wen, sdo, sdo_oe, addr, din}, 32'h0);
    rst = 1'b0;
    send(16'h0005, 8, 32'h9900_0000, rd, oc);
    check("rst_ignored_enable", {31'h0, en}, 32'h1 ^ 32'h1);
    frame_end();
    sb.push_back({8'h03, 8'h77});
    frame_start();
    send(16'h0003, 8, 32'h7700_0000, rd, oc);
    frame_end();
    check("rst_next_frame", sb.size(), 0);

    // Abort after 5 data bits of a write, then a clean write.
    frame_start();
    send(16'h0003, 5, 32'hFF00_0000, rd, oc);
    frame_end();
    check("abort_idle", {30'h0, en, sdo_oe}, 32'h0);
    sb.push_back({8'h03, 8'hC3});
    frame_start();
    send(16'h0003, 8, 32'hC300_0000, rd, oc);
    frame_end();
    check("abort_next_frame", sb.size(), 0);

    // CSB rise coincident with the 8th SCLK rise: the bit is discarded.
    frame_start();
    send(16'h0007, 7, 32'hFE00_0000, rd, oc);
    sdi = 1'b1;
    #HALF;
    csb = 1'b1;
    sclk = 1'b1;
    #HALF;
    sclk = 1'b0;
    sdi = 1'b0;
    repeat (8) @(negedge clk);
    check("collide_idle", {30'h0, en, wen}, 32'h0);
    check("final_sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
